// File: rtl/control_unit.sv
// Multicycle control FSM for the MIPS-subset datapath: fetch/decode, execution
// sequencing, memory wait states and exception entry through vector bytes 253..255.
module control_unit #(
    parameter int MEM_WAIT = 2,
    parameter int STATE_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               O,
    input  logic               EG,
    output logic               PCwrite,
    output logic               IrWrite,
    output logic               MDRwrite,
    output logic               Awrite,
    output logic               Bwrite,
    output logic               EPCcontrol,
    output logic               ALUoutCtrl,
    output logic               MEMwrite,
    output logic               RegWrite,
    output logic               ALUsrcA,
    output logic [1:0]         ALUsrcB,
    output logic [2:0]         ALUop,
    output logic [1:0]         IorD,
    output logic [1:0]         EXCPcontrol,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemToReg,
    output logic [1:0]         PCsrc,
    output logic [STATE_W-1:0] state
);

    localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_LW    = 6'h23, OP_SW   = 6'h2b;
    localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;

    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_DECODE, S_R_EX, S_R_WB, S_ADDI_EX, S_ADDI_WB,
        S_MEM_ADDR, S_LW_READ, S_LW_WB, S_SW_WRITE, S_BRANCH, S_J, S_JAL,
        S_JR, S_EXC_EPC, S_EXC_READ, S_EXC_JUMP
    } state_t;

    state_t           cur_state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       code, code_next;
    logic             last;
    logic             arith_ovf;

    assign last      = (cnt == CNT_W'(MEM_WAIT - 1));
    assign arith_ovf = O && ((funct == FN_ADD) || (funct == FN_SUB));
    assign state     = STATE_W'(cur_state);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_RESET;
            cnt       <= '0;
            code      <= '0;
        end else begin
            cur_state <= next_state;
            cnt       <= cnt_next;
            code      <= code_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        next_state = cur_state;
        code_next  = code;
        cnt_next   = '0;
        unique case (cur_state)
            S_RESET:  next_state = S_FETCH;
            S_FETCH: begin
                if (last) next_state = S_DECODE;
                else      cnt_next   = cnt + CNT_W'(1);
            end
            S_DECODE: begin
                unique case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND)
                            next_state = S_R_EX;
                        else if (funct == FN_JR)
                            next_state = S_JR;
                        else begin
                            next_state = S_EXC_EPC;
                            code_next  = 2'd0;
                        end
                    end
                    OP_ADDI:       next_state = S_ADDI_EX;
                    OP_LW, OP_SW:  next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J:          next_state = S_J;
                    OP_JAL:        next_state = S_JAL;
                    default: begin
                        next_state = S_EXC_EPC;
                        code_next  = 2'd0;
                    end
                endcase
            end
            S_R_EX: begin
                if (arith_ovf) begin
                    next_state = S_EXC_EPC;
                    code_next  = 2'd1;
                end else begin
                    next_state = S_R_WB;
                end
            end
            S_ADDI_EX: begin
                if (O) begin
                    next_state = S_EXC_EPC;
                    code_next  = 2'd1;
                end else begin
                    next_state = S_ADDI_WB;
                end
            end
            S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
            S_LW_READ: begin
                if (last) next_state = S_LW_WB;
                else      cnt_next   = cnt + CNT_W'(1);
            end
            S_EXC_EPC: next_state = S_EXC_READ;
            S_EXC_READ: begin
                if (last) next_state = S_EXC_JUMP;
                else      cnt_next   = cnt + CNT_W'(1);
            end
            S_R_WB, S_ADDI_WB, S_LW_WB, S_SW_WRITE, S_BRANCH,
            S_J, S_JAL, S_JR, S_EXC_JUMP: next_state = S_FETCH;
            default: next_state = S_RESET;
        endcase
    end

    always_comb begin
        PCwrite     = 1'b0;
        IrWrite     = 1'b0;
        MDRwrite    = 1'b0;
        Awrite      = 1'b0;
        Bwrite      = 1'b0;
        EPCcontrol  = 1'b0;
        ALUoutCtrl  = 1'b0;
        MEMwrite    = 1'b0;
        RegWrite    = 1'b0;
        ALUsrcA     = 1'b0;
        ALUsrcB     = 2'd0;
        ALUop       = 3'b000;
        IorD        = 2'd0;
        EXCPcontrol = 2'd0;
        RegDst      = 2'd0;
        MemToReg    = 2'd0;
        PCsrc       = 2'd0;
        unique case (cur_state)
            S_RESET: begin
                RegDst   = 2'd3;
                MemToReg = 2'd3;
                RegWrite = 1'b1;
            end
            S_FETCH: begin
                if (last) begin
                    ALUsrcB = 2'd1;
                    ALUop   = 3'b001;
                    PCwrite = 1'b1;
                    IrWrite = 1'b1;
                end
            end
            S_DECODE: begin
                Awrite     = 1'b1;
                Bwrite     = 1'b1;
                ALUsrcB    = 2'd3;
                ALUop      = 3'b001;
                ALUoutCtrl = 1'b1;
            end
            S_R_EX: begin
                ALUsrcA    = 1'b1;
                ALUoutCtrl = 1'b1;
                ALUop      = (funct == FN_SUB) ? 3'b010 :
                             (funct == FN_AND) ? 3'b011 : 3'b001;
            end
            S_R_WB: begin
                RegDst   = 2'd1;
                RegWrite = 1'b1;
            end
            S_ADDI_EX, S_MEM_ADDR: begin
                ALUsrcA    = 1'b1;
                ALUsrcB    = 2'd2;
                ALUop      = 3'b001;
                ALUoutCtrl = 1'b1;
            end
            S_ADDI_WB: RegWrite = 1'b1;
            S_LW_READ: begin
                IorD     = 2'd1;
                MDRwrite = last;
            end
            S_LW_WB: begin
                MemToReg = 2'd1;
                RegWrite = 1'b1;
            end
            S_SW_WRITE: begin
                IorD     = 2'd1;
                MEMwrite = 1'b1;
            end
            S_BRANCH: begin
                ALUsrcA = 1'b1;
                ALUop   = 3'b111;
                PCsrc   = 2'd1;
                PCwrite = (opcode == OP_BNE) ? ~EG : EG;
            end
            S_J: begin
                PCsrc   = 2'd2;
                PCwrite = 1'b1;
            end
            S_JAL: begin
                PCsrc    = 2'd2;
                PCwrite  = 1'b1;
                RegDst   = 2'd2;
                MemToReg = 2'd2;
                RegWrite = 1'b1;
            end
            S_JR: begin
                ALUsrcA = 1'b1;
                PCwrite = 1'b1;
            end
            S_EXC_EPC: begin
                ALUsrcB    = 2'd1;
                ALUop      = 3'b010;
                EPCcontrol = 1'b1;
            end
            S_EXC_READ: begin
                IorD        = 2'd2;
                EXCPcontrol = code;
                MDRwrite    = last;
            end
            S_EXC_JUMP: begin
                PCsrc   = 2'd3;
                PCwrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
